// File: rtl/timer_carga_teclado.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : timer_carga_teclado                                        |
// | Description : Keypad entry stage for the countdown timer digit chain.    |
// |               Shifts typed BCD digits into an mm:ss buffer, validates    |
// |               the seconds-tens digit on Enter and drives a one-cycle     |
// |               active-low load strobe to the digit counters.              |
// |               Optional macro TIMER_CARGA_TIMEOUT_EN adds an idle-entry   |
// |               timeout that abandons a half-typed entry.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module timer_carga_teclado #(
   parameter int DIGITS         = 4,
   parameter int SEC_TENS_MAX   = 5,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                  clk,
   input  logic                  clearn,
   input  logic                  key_valid,
   input  logic [3:0]            key_code,
   input  logic                  busy,
   output logic [4*DIGITS-1:0]   data_flat,
   output logic                  loadn,
   output logic [2:0]            digits_entered,
   output logic                  entry_active,
   output logic                  err
);

   localparam int         c_W         = 4 * DIGITS;
   localparam logic [2:0] c_DIGITS_3  = 3'(DIGITS);
   localparam logic [3:0] c_SEC_MAX   = 4'(SEC_TENS_MAX);
   localparam logic [3:0] c_KEY_CLEAR = 4'hA;
   localparam logic [3:0] c_KEY_ENTER = 4'hB;

   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_ENTRY  = 2'd1;
   localparam logic [1:0] c_ST_LOAD   = 2'd2;

   logic [1:0]     state_q, state_d;
   logic           key_prev_q;
   logic [c_W-1:0] data_q, data_d;
   logic [2:0]     count_q, count_d;
   logic           loadn_q, loadn_d;
   logic           err_q, err_d;

   logic           w_accept;
   logic           w_is_digit;
   logic           w_is_clear;
   logic           w_is_enter;
   logic           w_sec_ok;
   logic           w_timeout;

   // A key counts once per rising edge of key_valid; busy masks the accept
   // but not the edge tracking, so a key held through busy is never taken.
   assign w_accept   = key_valid & ~key_prev_q & ~busy;
   assign w_is_digit = (key_code <= 4'd9);
   assign w_is_clear = (key_code == c_KEY_CLEAR);
   assign w_is_enter = (key_code == c_KEY_ENTER);
   assign w_sec_ok   = (data_q[7:4] <= c_SEC_MAX);

`ifdef TIMER_CARGA_TIMEOUT_EN
   localparam int                 c_TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_TMO_W-1:0] c_TMO_RELOAD = c_TMO_W'(TIMEOUT_CYCLES - 1);

   logic [c_TMO_W-1:0] tmo_q, tmo_d;

   // Reload on every key taken in ENTRY, park at reload elsewhere, else count down.
   always_comb begin
      tmo_d = tmo_q;
      if ((state_q != c_ST_ENTRY) || w_accept) begin
         tmo_d = c_TMO_RELOAD;
      end else if (tmo_q != '0) begin
         tmo_d = tmo_q - 1'b1;
      end
   end

   // Idle-entry timeout counter register.
   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         tmo_q <= c_TMO_RELOAD;
      end else begin
         tmo_q <= tmo_d;
      end
   end

   assign w_timeout = (state_q == c_ST_ENTRY) && (tmo_q == '0);
`else
   logic w_unused_tmo;

   // Without the timeout an entry waits indefinitely; keep the parameter referenced.
   assign w_timeout    = 1'b0;
   assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

   // State register plus registered datapath and strobes.
   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         state_q    <= c_ST_IDLE;
         key_prev_q <= 1'b0;
         data_q     <= '0;
         count_q    <= 3'd0;
         loadn_q    <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         key_prev_q <= key_valid;
         data_q     <= data_d;
         count_q    <= count_d;
         loadn_q    <= loadn_d;
         err_q      <= err_d;
      end
   end

   // Next-state logic: digits open an entry, Enter validates, LOAD is one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ST_IDLE: begin
            if (w_accept && w_is_digit) begin
               state_d = c_ST_ENTRY;
            end
         end
         c_ST_ENTRY: begin
            if (w_accept) begin
               if (w_is_clear) begin
                  state_d = c_ST_IDLE;
               end else if (w_is_enter && (count_q != 3'd0)) begin
                  state_d = w_sec_ok ? c_ST_LOAD : c_ST_IDLE;
               end
            end else if (w_timeout) begin
               state_d = c_ST_IDLE;
            end
         end
         c_ST_LOAD: begin
            state_d = c_ST_IDLE;
         end
         default: begin
            state_d = c_ST_IDLE;
         end
      endcase
   end

   // Output/datapath logic: buffer shifting, count, load strobe and error pulse.
   always_comb begin
      data_d  = data_q;
      count_d = count_q;
      loadn_d = 1'b1;
      err_d   = 1'b0;
      case (state_q)
         c_ST_IDLE: begin
            if (w_accept) begin
               if (w_is_digit) begin
                  // A fresh entry discards whatever the last load left behind.
                  data_d  = c_W'(key_code);
                  count_d = 3'd1;
               end else if (w_is_clear) begin
                  data_d  = '0;
                  count_d = 3'd0;
               end
            end
         end
         c_ST_ENTRY: begin
            if (w_accept) begin
               if (w_is_digit) begin
                  if (count_q < c_DIGITS_3) begin
                     data_d  = (data_q << 4) | c_W'(key_code);
                     count_d = count_q + 3'd1;
                  end
               end else if (w_is_clear) begin
                  data_d  = '0;
                  count_d = 3'd0;
               end else if (w_is_enter && (count_q != 3'd0)) begin
                  if (w_sec_ok) begin
                     loadn_d = 1'b0;
                  end else begin
                     err_d   = 1'b1;
                     data_d  = '0;
                     count_d = 3'd0;
                  end
               end
            end else if (w_timeout) begin
               data_d  = '0;
               count_d = 3'd0;
            end
         end
         c_ST_LOAD: begin
            // Buffer stays on the counters' data inputs; only the count rewinds.
            count_d = 3'd0;
         end
         default: begin
            data_d  = '0;
            count_d = 3'd0;
         end
      endcase
   end

   assign data_flat      = data_q;
   assign loadn          = loadn_q;
   assign digits_entered = count_q;
   assign entry_active   = (state_q == c_ST_ENTRY);
   assign err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_carga_teclado.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_timer_carga_teclado                                     |
// | Description : Self-checking bench for timer_carga_teclado. A keypad      |
// |               entry model predicts every output each cycle; directed     |
// |               key sequences add hand-computed literal expectations.      |
// |               Timeout checks run when TIMER_CARGA_TIMEOUT_EN is defined. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_timer_carga_teclado;

   localparam int M_IDLE  = 0;
   localparam int M_ENTRY = 1;
   localparam int M_LOAD  = 2;
   localparam int TMO     = 8;

   logic        clk       = 1'b0;
   logic        clearn    = 1'b1;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code  = 4'h0;
   logic        busy      = 1'b0;
   logic [15:0] data_flat;
   logic        loadn;
   logic [2:0]  digits_entered;
   logic        entry_active;
   logic        err;

   int checks      = 0;
   int failures    = 0;
   int n_loadn_low = 0;
   int n_err_high  = 0;

   // Model of the entry: typed value, digit count, phase and expected strobes.
   int m_mode    = M_IDLE;
   int m_data    = 0;
   int m_count   = 0;
   int m_idle    = 0;
   bit m_prev    = 1'b0;
   bit exp_loadn = 1'b1;
   bit exp_err   = 1'b0;

   timer_carga_teclado #(
      .DIGITS         (4),
      .SEC_TENS_MAX   (5),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk            (clk),
      .clearn         (clearn),
      .key_valid      (key_valid),
      .key_code       (key_code),
      .busy           (busy),
      .data_flat      (data_flat),
      .loadn          (loadn),
      .digits_entered (digits_entered),
      .entry_active   (entry_active),
      .err            (err)
   );

   initial begin
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Entry model, advanced on each clock edge from the inputs seen before it.
   initial begin
      bit acc;
      forever begin
         @(posedge clk or negedge clearn);
         if (!clearn) begin
            m_mode = M_IDLE; m_data = 0; m_count = 0; m_idle = 0;
            m_prev = 1'b0; exp_loadn = 1'b1; exp_err = 1'b0;
         end else begin
            acc       = key_valid && !m_prev && !busy;
            m_prev    = key_valid;
            exp_loadn = 1'b1;
            exp_err   = 1'b0;
            if (m_mode == M_LOAD) begin
               m_mode  = M_IDLE;
               m_count = 0;
            end else if (acc) begin
               m_idle = 0;
               if (key_code <= 4'd9) begin
                  if (m_mode == M_IDLE) begin
                     m_data  = int'(key_code);
                     m_count = 1;
                     m_mode  = M_ENTRY;
                  end else if (m_count < 4) begin
                     m_data  = (m_data * 16 + int'(key_code)) % 65536;
                     m_count = m_count + 1;
                  end
               end else if (key_code == 4'hA) begin
                  m_data = 0; m_count = 0; m_mode = M_IDLE;
               end else if (key_code == 4'hB && m_mode == M_ENTRY && m_count > 0) begin
                  if ((m_data / 16) % 16 <= 5) begin
                     m_mode    = M_LOAD;
                     exp_loadn = 1'b0;
                  end else begin
                     exp_err = 1'b1;
                     m_data = 0; m_count = 0; m_mode = M_IDLE;
                  end
               end
            end else if (m_mode == M_ENTRY) begin
`ifdef TIMER_CARGA_TIMEOUT_EN
               m_idle = m_idle + 1;
               if (m_idle == TMO) begin
                  m_data = 0; m_count = 0; m_mode = M_IDLE; m_idle = 0;
               end
`endif
            end
         end
      end
   end

   // Every-cycle comparison of the DUT against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (clearn) begin
            check("data_flat", 32'(data_flat), 32'(m_data));
            check("digits_entered", 32'(digits_entered), 32'(m_count));
            check("entry_active", 32'(entry_active), 32'(m_mode == M_ENTRY));
            check("loadn", 32'(loadn), 32'(exp_loadn));
            check("err", 32'(err), 32'(exp_err));
            if (loadn === 1'b0) n_loadn_low++;
            if (err === 1'b1) n_err_high++;
         end
      end
   end

   task automatic press(input logic [3:0] code);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = code;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clearn = 1'b0;
      @(negedge clk);
      clearn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1: reset state, then 1,3,4,5 + Enter loads 16'h1345.
      #1 clearn = 1'b0;
      #2;
      check("rst_data", 32'(data_flat), 32'h0);
      check("rst_loadn", 32'(loadn), 32'h1);
      check("rst_err", 32'(err), 32'h0);
      check("rst_count", 32'(digits_entered), 32'h0);
      check("rst_entry", 32'(entry_active), 32'h0);
      @(negedge clk);
      @(negedge clk);
      clearn = 1'b1;
      press(4'h1); press(4'h3); press(4'h4); press(4'h5);
      check("t1_data", 32'(data_flat), 32'h1345);
      check("t1_count", 32'(digits_entered), 32'd4);
      check("t1_entry", 32'(entry_active), 32'h1);
      press(4'hB);
      check("t1_loadn_low", 32'(loadn), 32'h0);
      @(negedge clk);
      check("t1_loadn_high", 32'(loadn), 32'h1);
      check("t1_count_after", 32'(digits_entered), 32'd0);
      check("t1_entry_after", 32'(entry_active), 32'h0);
      check("t1_data_kept", 32'(data_flat), 32'h1345);

      // 2: 2,7 loads; 9,0 has seconds tens 9 and is rejected.
      press(4'h2);
      check("t2_fresh_entry", 32'(data_flat), 32'h0002);
      press(4'h7);
      press(4'hB);
      check("t2_data", 32'(data_flat), 32'h0027);
      check("t2_loadn", 32'(loadn), 32'h0);
      press(4'h9); press(4'h0);
      check("t2_bad_data", 32'(data_flat), 32'h0090);
      press(4'hB);
      check("t2_err", 32'(err), 32'h1);
      check("t2_err_loadn", 32'(loadn), 32'h1);
      check("t2_err_data", 32'(data_flat), 32'h0);
      @(negedge clk);
      check("t2_err_gone", 32'(err), 32'h0);

      // 3: overflow digits ignored, unused code ignored, Clear empties.
      press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5); press(4'h6);
      check("t3_data", 32'(data_flat), 32'h1234);
      check("t3_count", 32'(digits_entered), 32'd4);
      press(4'hE);
      check("t3_ignored", 32'(data_flat), 32'h1234);
      press(4'hA);
      check("t3_clear_data", 32'(data_flat), 32'h0);
      check("t3_clear_entry", 32'(entry_active), 32'h0);

      // 4: held key accepted once; busy masks keys, including one held through busy.
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = 4'h7;
      repeat (10) @(negedge clk);
      key_valid = 1'b0;
      check("t4_held", 32'(data_flat), 32'h0007);
      check("t4_held_count", 32'(digits_entered), 32'd1);
      busy = 1'b1;
      press(4'h8);
      busy = 1'b0;
      check("t4_busy", 32'(data_flat), 32'h0007);
      @(negedge clk);
      busy = 1'b1; key_valid = 1'b1; key_code = 4'h9;
      repeat (3) @(negedge clk);
      busy = 1'b0;
      repeat (3) @(negedge clk);
      key_valid = 1'b0;
      check("t4_held_thru_busy", 32'(data_flat), 32'h0007);
      do_reset();
      press(4'hB);
      check("t4_idle_enter_loadn", 32'(loadn), 32'h1);
      check("t4_idle_enter_err", 32'(err), 32'h0);

      // 5: reset during LOAD drops the strobe at once and nothing follows.
      press(4'h3); press(4'h0);
      press(4'hB);
      check("t5_loadn_low", 32'(loadn), 32'h0);
      #2 clearn = 1'b0;
      #1;
      check("t5_async_loadn", 32'(loadn), 32'h1);
      check("t5_async_data", 32'(data_flat), 32'h0);
      @(negedge clk);
      clearn = 1'b1;
      repeat (4) @(negedge clk);
      check("loadn_pulses", 32'(n_loadn_low), 32'd3);
      check("err_pulses", 32'(n_err_high), 32'd1);

`ifdef TIMER_CARGA_TIMEOUT_EN
      // 6: abandoned entry clears after TMO idle cycles; a key restarts the count.
      press(4'h5);
      check("t6_entry", 32'(entry_active), 32'h1);
      repeat (7) @(negedge clk);
      check("t6_before_tmo", 32'(entry_active), 32'h1);
      @(negedge clk);
      check("t6_tmo_entry", 32'(entry_active), 32'h0);
      check("t6_tmo_data", 32'(data_flat), 32'h0);
      check("t6_tmo_err", 32'(err), 32'h0);
      press(4'h5);
      repeat (5) @(negedge clk);
      press(4'h6);
      repeat (7) @(negedge clk);
      check("t6_restart_entry", 32'(entry_active), 32'h1);
      check("t6_restart_data", 32'(data_flat), 32'h0056);
      @(negedge clk);
      check("t6_restart_tmo", 32'(entry_active), 32'h0);
`endif

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/timer_carga_teclado.md
Name: timer_carga_teclado

Overview:
Upstream keypad-entry stage for the countdown timer digit chain. Collects BCD digits typed on the keypad, shifts them into an mm:ss buffer and validates the entry on the Enter key. It then drives the parallel `data` inputs of each mod-10/mod-6 digit counter and issues a single-cycle active-low `loadn` pulse. Entry is locked out while the timer is counting.

Parameters:
DIGITS, 4, number of BCD digits held (mm:ss); `data_flat` width is 4*DIGITS
SEC_TENS_MAX, 5, largest legal value of digit index 1 (seconds tens)
TIMEOUT_CYCLES, 1000, idle-entry timeout in clk cycles (used only with TIMER_CARGA_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
clearn  in  1  reset, asynchronous, active-low
key_valid  in  1  keypad strobe, level; one key accepted per rising edge
key_code  in  4  0-9 digit, 4'hA clear, 4'hB enter, 4'hC-4'hF ignored
busy  in  1  timer counting; all keys ignored while high
data_flat  out  4*DIGITS  digit buffer; [3:0] seconds ones, [7:4] seconds tens, [11:8] minutes ones, [15:12] minutes tens
loadn  out  1  active-low load strobe to the digit counters, one cycle
digits_entered  out  3  count of digits typed, saturates at DIGITS
entry_active  out  1  high in state ENTRY
err  out  1  one-cycle pulse on rejected Enter

Behaviour:
- Reset (clearn=0, asynchronous):
  - data_flat=0, loadn=1, err=0, digits_entered=0, entry_active=0, state=IDLE.
  - The key edge-detect register clears to 0.
- Key accept: at a clk edge where key_valid=1, the edge register is 0 and busy=0. All effects are visible after that same edge. A key_valid held high gives exactly one accept.
- busy=1: no accept, and the edge register still tracks key_valid. A key held across the busy→0 falling edge is not accepted.
- FSM states: IDLE, ENTRY, LOAD.
- Digit 0-9, in IDLE or ENTRY:
  - If digits_entered<DIGITS: data_flat <= {data_flat[4*DIGITS-5:0], key_code}, digits_entered+1, state=ENTRY.
  - If digits_entered==DIGITS: the digit is ignored; buffer and count are unchanged.
- Digit 0-9 in IDLE: the buffer is first treated as cleared, so the new entry starts as {0..0, key_code} with count=1.
- Clear (4'hA), any state except LOAD: data_flat=0, digits_entered=0, state=IDLE, no loadn.
- Enter (4'hB):
  - In IDLE, or with digits_entered=0: ignored.
  - In ENTRY with data_flat[7:4] <= SEC_TENS_MAX: state=LOAD.
  - In ENTRY with data_flat[7:4] > SEC_TENS_MAX: err=1 for one cycle, data_flat=0, digits_entered=0, state=IDLE.
- LOAD:
  - Lasts exactly one cycle with loadn=0 (registered).
  - data_flat is stable for this cycle and unchanged after it.
  - Next state is IDLE, with digits_entered=0 and data_flat retained.
  - Any key accepted during LOAD is dropped.
- Codes 4'hC-4'hF: no effect in any state.
- loadn and err are never asserted in the same cycle. Neither is ever asserted for more than one consecutive cycle.
- Reset mid-LOAD: loadn returns to 1 immediately (asynchronously); no partial load is retried.

Optional Feature:
Macro: TIMER_CARGA_TIMEOUT_EN.
- Defined:
  - A down-counter loads TIMEOUT_CYCLES-1 on every accepted key in ENTRY.
  - If it reaches 0 while still in ENTRY: data_flat=0, digits_entered=0, state=IDLE. No err is raised.
  - The counter is held at its reload value outside ENTRY.
- Undefined: no counter logic is generated; ENTRY persists indefinitely.

Test Plan:
1. Reset release; keys 1,3,4,5 then Enter → data_flat=16'h1345, digits_entered=4 before Enter; loadn=0 for exactly 1 cycle one edge after Enter accept; state IDLE, digits_entered=0.
2. Keys 2,7 then Enter → data_flat=16'h0027, loadn pulse. Then keys 9,0 (seconds tens 9) then Enter → err=1 for 1 cycle, no loadn, data_flat=0.
3. Keys 1,2,3,4,5,6 → data_flat=16'h1234 (5 and 6 ignored), digits_entered=4. Clear → data_flat=0, entry_active=0.
4. key_valid held high for 10 cycles with code 7 → single accept, data_flat=16'h0007. Key 8 with busy=1 → no change. Enter in IDLE after reset → no loadn, no err.
5. Assert clearn=0 during the LOAD cycle → loadn=1 and data_flat=0 immediately; no pulse after release.
6. With TIMER_CARGA_TIMEOUT_EN and TIMEOUT_CYCLES=8: key 5, then idle 8 cycles → data_flat=0, entry_active=0, err=0. Key at cycle 7 restarts the count.
